// File: rtl/fmdll_ratio_ctrl_pkg.sv
// Shared types and constants for the FMDLL ratio configuration and lock sequencer.
package fmdll_pkg;

  localparam int unsigned N_W      = 4;
  localparam int unsigned M_W      = 2;
  localparam int unsigned ALIGN_TO = 8;

  localparam logic [N_W-1:0] N_DEF = N_W'(1);
  localparam logic [M_W-1:0] M_DEF = M_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TRACK  = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  typedef struct packed {
    logic [N_W-1:0] n;
    logic [M_W-1:0] m;
  } ratio_t;

  // Width of a counter that must hold 0..bound-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

  localparam int unsigned ALIGN_W = cnt_w(ALIGN_TO);

  function automatic logic ratio_legal(input ratio_t r);
    return (r.n != '0) && (r.m != '0);
  endfunction

endpackage

// File: rtl/fmdll_ratio_ctrl_if.sv
// Ratio request channel: valid/ready handshake carrying the requested N/M.
interface fmdll_ratio_ctrl_if;
  import fmdll_pkg::*;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [N_W-1:0] cfg_N;
  logic [M_W-1:0] cfg_M;

  modport master (output cfg_valid, output cfg_N, output cfg_M, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_N, input cfg_M, output cfg_ready);

endinterface

// File: rtl/fmdll_ratio_ctrl_run_det.sv
// Saturating consecutive-run counter; term_c flags the sample that completes a run of LIMIT hits.
module fmdll_run_det #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_ext,
  input  logic rst,
  input  logic hit,
  input  logic clr,
  output logic term_c
);

  localparam int unsigned   CW      = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign term_c = hit && !clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fmdll_ratio_ctrl.sv
// FMDLL ratio sequencer: accepts N/M requests, loads them at the M-counter wrap,
// then walks the loop through settle, tracking and lock using phase-detector balance.
module fmdll_ratio_ctrl
  import fmdll_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned TO_CYC     = 1024
) (
  input  logic                clk_ext,
  input  logic                rst,
  fmdll_ratio_ctrl_if.slave   cfg,
  input  logic [M_W-1:0]      M_counter,
  input  logic                pd_up,
  input  logic                pd_dn,
  output logic [N_W-1:0]      N,
  output logic [M_W-1:0]      M,
  output logic                Sel,
  output logic                locked,
  output logic                err,
  output logic                cfg_err
);

  localparam int unsigned SET_W = cnt_w(SETTLE_CYC);
  localparam int unsigned TO_W  = cnt_w(TO_CYC);

  localparam logic [SET_W-1:0]   SET_LAST   = SET_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TO_CYC - 1);
  localparam logic [ALIGN_W-1:0] ALIGN_LAST = ALIGN_W'(ALIGN_TO - 1);

  state_e             st_q, st_d;
  ratio_t             sh_q, sh_d;
  logic [N_W-1:0]     n_d;
  logic [M_W-1:0]     m_d;
  logic               sel_d, locked_d, err_d, cfg_err_d, rdy_q, rdy_d;
  logic [ALIGN_W-1:0] align_cnt_q, align_cnt_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

  ratio_t req_c;
  logic   bal_c, acc_c, acq_hit_c, loss_hit_c, acq_term_c, loss_term_c;

  assign req_c         = {cfg.cfg_N, cfg.cfg_M};
  assign bal_c         = (pd_up == pd_dn);
  assign acc_c         = cfg.cfg_valid && rdy_q;
  assign acq_hit_c     = (st_q == ST_TRACK) && bal_c;
  assign loss_hit_c    = (st_q == ST_LOCKED) && !bal_c;
  assign cfg.cfg_ready = rdy_q;

  // Balanced-run detector for lock acquisition, unbalanced-run detector for lock loss.
  fmdll_run_det #(.LIMIT(LOCK_CNT)) u_acq (
    .clk_ext (clk_ext),
    .rst     (rst),
    .hit     (acq_hit_c),
    .clr     (!acq_hit_c),
    .term_c  (acq_term_c)
  );

  fmdll_run_det #(.LIMIT(LOCK_CNT)) u_loss (
    .clk_ext (clk_ext),
    .rst     (rst),
    .hit     (loss_hit_c),
    .clr     (!loss_hit_c),
    .term_c  (loss_term_c)
  );

  // Next-state and registered-output decode; an accepted request overrides everything.
  always_comb begin
    st_d         = st_q;
    sh_d         = sh_q;
    n_d          = N;
    m_d          = M;
    sel_d        = Sel;
    locked_d     = locked;
    err_d        = err;
    cfg_err_d    = 1'b0;
    align_cnt_d  = '0;
    settle_cnt_d = '0;
    to_cnt_d     = '0;

    if (acc_c && !ratio_legal(req_c)) begin
      cfg_err_d = 1'b1;
    end

    if (acc_c && ratio_legal(req_c)) begin
      sh_d     = req_c;
      st_d     = ST_ALIGN;
      sel_d    = 1'b0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (st_q)
        ST_ALIGN: begin
          if (M_counter == M) begin
            n_d  = sh_q.n;
            m_d  = sh_q.m;
            st_d = ST_SETTLE;
          end else if (align_cnt_q == ALIGN_LAST) begin
            st_d  = ST_FAIL;
            err_d = 1'b1;
          end else begin
            align_cnt_d = align_cnt_q + ALIGN_W'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SET_LAST) begin
            st_d  = ST_TRACK;
            sel_d = 1'b1;
          end else begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end
        ST_TRACK: begin
          if (acq_term_c) begin
            st_d     = ST_LOCKED;
            locked_d = 1'b1;
          end else if (to_cnt_q == TO_LAST) begin
            st_d     = ST_FAIL;
            sel_d    = 1'b0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_LOCKED: begin
          if (loss_term_c) begin
            st_d     = ST_TRACK;
            locked_d = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end

    rdy_d = (st_d == ST_IDLE) || (st_d == ST_LOCKED) || (st_d == ST_FAIL);
  end

  always_ff @(posedge clk_ext) begin
    if (rst) begin
      st_q         <= ST_IDLE;
      sh_q         <= {N_DEF, M_DEF};
      N            <= N_DEF;
      M            <= M_DEF;
      Sel          <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      cfg_err      <= 1'b0;
      rdy_q        <= 1'b1;
      align_cnt_q  <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
    end else begin
      st_q         <= st_d;
      sh_q         <= sh_d;
      N            <= n_d;
      M            <= m_d;
      Sel          <= sel_d;
      locked       <= locked_d;
      err          <= err_d;
      cfg_err      <= cfg_err_d;
      rdy_q        <= rdy_d;
      align_cnt_q  <= align_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_fmdll_ratio_ctrl.sv
// Scoreboard bench for fmdll_ratio_ctrl: a cycle reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_fmdll_ratio_ctrl;

  localparam int unsigned TB_SETTLE = 10;
  localparam int unsigned TB_LOCK   = 5;
  localparam int unsigned TB_TO     = 60;
  localparam int          ALIGN_MAX = 8;

  localparam int P_IDLE = 0, P_ALIGN = 1, P_SETTLE = 2, P_TRACK = 3, P_LOCKED = 4, P_FAIL = 5;

  typedef struct packed {
    logic [3:0] n;
    logic [1:0] m;
    logic       sel;
    logic       lck;
    logic       err;
    logic       cerr;
    logic       rdy;
  } obs_t;

  logic       clk_ext = 1'b0;
  logic       rst;
  logic [1:0] M_counter;
  logic       pd_up, pd_dn;
  logic [3:0] N;
  logic [1:0] M;
  logic       Sel, locked, err, cfg_err;

  fmdll_ratio_ctrl_if cfg_if ();

  fmdll_ratio_ctrl #(
    .SETTLE_CYC (TB_SETTLE),
    .LOCK_CNT   (TB_LOCK),
    .TO_CYC     (TB_TO)
  ) dut (
    .clk_ext   (clk_ext),
    .rst       (rst),
    .cfg       (cfg_if),
    .M_counter (M_counter),
    .pd_up     (pd_up),
    .pd_dn     (pd_dn),
    .N         (N),
    .M         (M),
    .Sel       (Sel),
    .locked    (locked),
    .err       (err),
    .cfg_err   (cfg_err)
  );

  always #5 clk_ext = ~clk_ext;

  obs_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  string phase  = "reset";

  // Reference model state (spec-level bookkeeping with plain integers).
  int ph = P_IDLE;
  int app_n = 1, app_m = 1, req_n = 1, req_m = 1;
  int o_sel = 0, o_lck = 0, o_err = 0, o_cerr = 0, o_rdy = 1;
  int align_waits = 0, settle_len = 0, track_len = 0, bal_run = 0, unbal_run = 0;

  task automatic model_step();
    int  cn, cm;
    bit  bal, acc;
    cn = int'(cfg_if.cfg_N);
    cm = int'(cfg_if.cfg_M);
    if (rst) begin
      ph = P_IDLE; app_n = 1; app_m = 1; req_n = 1; req_m = 1;
      o_sel = 0; o_lck = 0; o_err = 0; o_cerr = 0; o_rdy = 1;
      align_waits = 0; settle_len = 0; track_len = 0; bal_run = 0; unbal_run = 0;
    end else begin
      bal    = (pd_up == pd_dn);
      acc    = (cfg_if.cfg_valid == 1'b1) && (o_rdy == 1);
      o_cerr = (acc && (cn == 0 || cm == 0)) ? 1 : 0;
      if (acc && cn != 0 && cm != 0) begin
        req_n = cn; req_m = cm;
        ph = P_ALIGN; align_waits = 0;
        o_sel = 0; o_lck = 0; o_err = 0;
      end else begin
        case (ph)
          P_ALIGN: begin
            if (int'(M_counter) == app_m) begin
              app_n = req_n; app_m = req_m;
              ph = P_SETTLE; settle_len = 0;
            end else begin
              align_waits++;
              if (align_waits == ALIGN_MAX) begin
                ph = P_FAIL; o_err = 1; o_sel = 0; o_lck = 0;
              end
            end
          end
          P_SETTLE: begin
            settle_len++;
            if (settle_len == int'(TB_SETTLE)) begin
              ph = P_TRACK; o_sel = 1; track_len = 0; bal_run = 0;
            end
          end
          P_TRACK: begin
            track_len++;
            bal_run = bal ? bal_run + 1 : 0;
            if (bal_run == int'(TB_LOCK)) begin
              ph = P_LOCKED; o_lck = 1; unbal_run = 0;
            end else if (track_len == int'(TB_TO)) begin
              ph = P_FAIL; o_err = 1; o_sel = 0; o_lck = 0;
            end
          end
          P_LOCKED: begin
            unbal_run = bal ? 0 : unbal_run + 1;
            if (unbal_run == int'(TB_LOCK)) begin
              ph = P_TRACK; o_lck = 0; track_len = 0; bal_run = 0;
            end
          end
          default: begin
          end
        endcase
      end
      o_rdy = (ph == P_IDLE || ph == P_LOCKED || ph == P_FAIL) ? 1 : 0;
    end
  endtask

  // Model: one expected output vector per active edge.
  initial forever begin
    obs_t e;
    @(posedge clk_ext);
    cyc++;
    model_step();
    e = {4'(app_n), 2'(app_m), 1'(o_sel), 1'(o_lck), 1'(o_err), 1'(o_cerr), 1'(o_rdy)};
    exp_q.push_back(e);
  end

  // Monitor: compare the DUT outputs at mid-cycle against the oldest expectation.
  initial forever begin
    obs_t e, a;
    @(negedge clk_ext);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {N, M, Sel, locked, err, cfg_err, cfg_if.cfg_ready};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d phase=%s actual N=%0d M=%0d Sel=%b locked=%b err=%b cfg_err=%b cfg_ready=%b required N=%0d M=%0d Sel=%b locked=%b err=%b cfg_err=%b cfg_ready=%b",
                 cyc, phase, a.n, a.m, a.sel, a.lck, a.err, a.cerr, a.rdy,
                 e.n, e.m, e.sel, e.lck, e.err, e.cerr, e.rdy);
      end
    end
  end

  // Stimulus generators for M_counter and the phase detector.
  int mc_mode = 0;   // 0: 1,2 alternate  1: hold 0  2: random  3: ramp 0..3
  int pd_mode = 0;   // 0: both low  1: random, biased  2: pd_up toggles every 3  3: up only
  int bal_pct = 90;
  int tog_cnt = 0;

  task automatic tick();
    bit b;
    @(negedge clk_ext);
    case (mc_mode)
      0:       M_counter = (M_counter == 2'd1) ? 2'd2 : 2'd1;
      1:       M_counter = 2'd0;
      2:       M_counter = 2'($urandom_range(0, 3));
      default: M_counter = M_counter + 2'd1;
    endcase
    case (pd_mode)
      0: begin pd_up = 1'b0; pd_dn = 1'b0; end
      1: begin
        b = ($urandom_range(0, 99) < bal_pct);
        pd_up = 1'($urandom_range(0, 1));
        pd_dn = b ? pd_up : ~pd_up;
      end
      2: begin
        tog_cnt++;
        if (tog_cnt == 3) begin pd_up = ~pd_up; tog_cnt = 0; end
        pd_dn = 1'b0;
      end
      default: begin pd_up = 1'b1; pd_dn = 1'b0; end
    endcase
  endtask

  task automatic send(input int n, input int m);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_N     = 4'(n);
    cfg_if.cfg_M     = 2'(m);
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; M_counter = 2'd0; pd_up = 1'b0; pd_dn = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_N = 4'd0; cfg_if.cfg_M = 2'd0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    phase = "illegal_idle";
    send(0, 2); repeat (2) tick();
    send(5, 0); repeat (2) tick();

    phase = "basic_lock";
    mc_mode = 0; pd_mode = 0;
    send(4, 2); repeat (25) tick();

    phase = "illegal_locked";
    send(0, 0); repeat (2) tick();

    phase = "loss";
    pd_mode = 3; repeat (TB_LOCK + 3) tick();
    pd_mode = 0; repeat (TB_LOCK + 3) tick();

    phase = "reconfig_on_loss";
    pd_mode = 3; tick(); repeat (TB_LOCK - 1) tick();
    mc_mode = 1;
    send(7, 3);
    pd_mode = 0;
    phase = "align_timeout";
    repeat (12) tick();

    phase = "track_timeout";
    mc_mode = 3; pd_mode = 2; tog_cnt = 0; pd_up = 1'b0;
    send(9, 2); repeat (TB_SETTLE + TB_TO + 20) tick();

    phase = "recover_from_fail";
    pd_mode = 0;
    send(3, 1); repeat (25) tick();

    phase = "reset_mid_settle";
    send(11, 3); repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (3) tick();

    phase = "random_soak";
    mc_mode = 2; pd_mode = 1;
    for (int ep = 0; ep < 4; ep++) begin
      bal_pct = (ep == 0) ? 97 : (ep == 1) ? 75 : (ep == 2) ? 25 : 55;
      for (int i = 0; i < 600; i++) begin
        cfg_if.cfg_valid = ($urandom_range(0, 15) == 0);
        cfg_if.cfg_N     = 4'($urandom_range(0, 15));
        cfg_if.cfg_M     = 2'($urandom_range(0, 3));
        rst              = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    cfg_if.cfg_valid = 1'b0; rst = 1'b0;
    repeat (3) tick();
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
